// File: rtl/pea_result_reader_pkg.sv
// Shared definitions for the PEA result reader: FSM state encodings,
// PEA status bit positions and a constant log2 helper.
package pea_result_reader_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  // Bit 0 of a PEA status word flags an errored computation.
  localparam int STATUS_ERR_BIT = 0;

  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pea_pair_hold_reg.sv
// {status, result} holding register: loads on request and keeps its contents
// stable while a presented pair is stalled by the downstream.
module pea_pair_hold_reg #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             valid,
  input  logic             ready,
  input  logic [width-1:0] result_in,
  input  logic [width-1:0] status_in,
  output logic [width-1:0] result_q,
  output logic [width-1:0] status_q
);

  logic stall;
  assign stall = valid && !ready;

  // NOTE: the data registers are reset too, because the block must present
  // all-zero outputs while in reset, not whatever the last pair happened to be.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      status_q <= '0;
    end else if (load && !stall) begin
      result_q <= result_in;
      status_q <= status_in;
    end
  end

endmodule

// File: rtl/pea_result_reader.sv
// Drains the lockstep PEA result/status FIFOs into one valid/ready stream.
// Optional macro PEA_RDR_STATUS_DROP_EN discards pairs whose status flags an error.
module pea_result_reader
  import pea_result_reader_pkg::*;
#(
  parameter int buffer_size_out = 32,
  parameter int width           = 32,
  parameter int cnt_w           = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [log2(buffer_size_out)-1:0]   result_pop,
  input  logic [log2(buffer_size_out)-1:0]   status_pop,
  input  logic [width-1:0]                   result_data,
  input  logic [width-1:0]                   status_data,
  output logic                               rd_en_result,
  output logic                               rd_en_status,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [width-1:0]                   out_result,
  output logic [width-1:0]                   out_status,
  output logic [cnt_w-1:0]                   pair_count,
  output logic [cnt_w-1:0]                   drop_count,
  output logic                               desync_err,
  output logic                               busy
);

  logic [1:0] state, state_next;
  logic       both_avail;
  logic       drop_pair;
  logic       accept;

  assign both_avail = (result_pop != '0) && (status_pop != '0);
  assign accept     = (state == HOLD) && out_ready;

`ifdef PEA_RDR_STATUS_DROP_EN
  assign drop_pair = (state == CAPT) && status_data[STATUS_ERR_BIT];
`else
  assign drop_pair = 1'b0;
`endif

  // NOTE: every path through this block assigns state_next because of the
  // default on the first line; without it the case would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (both_avail) state_next = POP;
      POP:  state_next = CAPT;
      CAPT: begin
        if (drop_pair) state_next = both_avail ? POP : IDLE;
        else           state_next = HOLD;
      end
      HOLD: if (out_ready) state_next = both_avail ? POP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pair_count <= '0;
      desync_err <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) pair_count <= pair_count + 1'b1;
      if ((state == IDLE) && (result_pop != status_pop)) desync_err <= 1'b1;
    end
  end

`ifdef PEA_RDR_STATUS_DROP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           drop_count <= '0;
    else if (drop_pair) drop_count <= drop_count + 1'b1;
  end
`else
  assign drop_count = '0;
`endif

  // Both FIFOs are popped together so the pair stays aligned.
  assign rd_en_result = (state == POP);
  assign rd_en_status = (state == POP);
  assign out_valid    = (state == HOLD);
  assign busy         = (state != IDLE);

  pea_pair_hold_reg #(
    .width (width)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      ((state == CAPT) && !drop_pair),
    .valid     (out_valid),
    .ready     (out_ready),
    .result_in (result_data),
    .status_in (status_data),
    .result_q  (out_result),
    .status_q  (out_status)
  );

endmodule

// File: tb/tb_pea_result_reader.sv
// Self-checking bench for pea_result_reader: FIFO models feed the DUT and a
// scoreboard queue of expected {status,result} pairs is compared on delivery.
module tb_pea_result_reader;
  import pea_result_reader_pkg::*;

  localparam int BSO = 32;
  localparam int W   = 32;
  localparam int CW  = 16;
  localparam int PW  = log2(BSO);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] result_pop = '0;
  logic [PW-1:0] status_pop = '0;
  logic [W-1:0]  result_data = '0;
  logic [W-1:0]  status_data = '0;
  logic          rd_en_result, rd_en_status;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result, out_status;
  logic [CW-1:0] pair_count, drop_count;
  logic          desync_err, busy;

  logic [W-1:0]   rq[$];
  logic [W-1:0]   sq[$];
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] got_q[$];

  int checks = 0;
  int failures = 0;
  int rd_res_cnt = 0;
  int rd_sta_cnt = 0;
  int rd_mis = 0;
  int underflow = 0;

  always #5 clk = ~clk;

  pea_result_reader #(
    .buffer_size_out (BSO),
    .width           (W),
    .cnt_w           (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .result_pop   (result_pop),
    .status_pop   (status_pop),
    .result_data  (result_data),
    .status_data  (status_data),
    .rd_en_result (rd_en_result),
    .rd_en_status (rd_en_status),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_status   (out_status),
    .pair_count   (pair_count),
    .drop_count   (drop_count),
    .desync_err   (desync_err),
    .busy         (busy)
  );

  // FIFO read model: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en_result) begin
      if (rq.size() == 0) underflow++;
      else result_data <= rq.pop_front();
    end
    if (rd_en_status) begin
      if (sq.size() == 0) underflow++;
      else status_data <= sq.pop_front();
    end
  end

  // Populations follow the queues, updated just after each falling edge.
  always begin
    @(negedge clk);
    #1;
    result_pop = PW'(rq.size());
    status_pop = PW'(sq.size());
  end

  // Monitor samples handshakes and strobes just before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (out_valid && out_ready) got_q.push_back({out_status, out_result});
    if (rd_en_result) rd_res_cnt++;
    if (rd_en_status) rd_sta_cnt++;
    if (rd_en_result != rd_en_status) rd_mis++;
  end

  task automatic push_pair(input logic [W-1:0] r, input logic [W-1:0] s, input bit expect_out);
    rq.push_back(r);
    sq.push_back(s);
    if (expect_out) exp_q.push_back({s, r});
  endtask

  task automatic wait_pairs(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    rq.delete();
    sq.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    got_q.delete();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [2*W-1:0] g, e;
    rst = 1'b0;
    @(negedge clk);
    push_pair(32'h55, 32'h0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if ({rd_en_result, rd_en_status, out_valid, desync_err, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {rd_en_result, rd_en_status, out_valid, desync_err, busy});
    end
    checks++;
    if ({out_result, out_status, pair_count, drop_count} !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h/%h/%0d/%0d expected all zero", out_result, out_status, pair_count, drop_count);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_en_result !== 1'b1 || rd_en_status !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_rd: got %b%b expected 11", rd_en_result, rd_en_status);
    end
    wait_pairs(1, 20);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL reset_release_pairs: got %0d expected 1", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL reset_pair: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_single();
    int r0, s0;
    logic [2*W-1:0] g, e;
    apply_reset();
    @(negedge clk);
    r0 = rd_res_cnt;
    s0 = rd_sta_cnt;
    push_pair(32'h0000_002A, 32'h0, 1'b1);
    @(negedge clk);
    checks++;
    if ({rd_en_result, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL single_c1: got rd/valid %b expected 10", {rd_en_result, out_valid});
    end
    @(negedge clk);
    checks++;
    if ({rd_en_result, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL single_c2: got rd/valid %b expected 00", {rd_en_result, out_valid});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h2A || out_status !== 32'h0) begin
      failures++;
      $display("FAIL single_c3: got valid %b %h/%h expected 1 0000002a/00000000", out_valid, out_result, out_status);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || pair_count !== 16'd1) begin
      failures++;
      $display("FAIL single_after: got valid %b count %0d expected 0 1", out_valid, pair_count);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rd_res_cnt - r0 != 1 || rd_sta_cnt - s0 != 1) begin
      failures++;
      $display("FAIL single_pulses: got %0d/%0d expected 1/1", rd_res_cnt - r0, rd_sta_cnt - s0);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL single_pair: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int r0, low;
    logic [2*W-1:0] g, e;
    apply_reset();
    @(negedge clk);
    r0 = rd_res_cnt;
    low = 0;
    for (int i = 1; i <= 3; i++) push_pair(W'(i), 32'h0, 1'b1);
    for (int c = 0; c < 80 && got_q.size() < 3; c++) begin
      @(negedge clk);
      if (out_valid && got_q.size() == 1 && low < 5) begin
        out_ready = 1'b0;
        low++;
        checks++;
        if (out_result !== 32'd2 || out_status !== 32'd0) begin
          failures++;
          $display("FAIL bp_hold: got %h/%h expected 00000002/00000000", out_result, out_status);
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (low != 5) begin failures++; $display("FAIL bp_stall_cycles: got %0d expected 5", low); end
    checks++;
    if (got_q.size() != 3) begin failures++; $display("FAIL bp_count_q: got %0d expected 3", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL bp_order: got %h expected %h", g, e); end
    end
    checks++;
    if (pair_count !== 16'd3 || busy !== 1'b0 || rd_res_cnt - r0 != 3) begin
      failures++;
      $display("FAIL bp_final: got count %0d busy %b pops %0d expected 3 0 3", pair_count, busy, rd_res_cnt - r0);
    end
  endtask

  task automatic test_desync();
    int r0;
    logic [2*W-1:0] g, e;
    apply_reset();
    @(negedge clk);
    r0 = rd_res_cnt;
    push_pair(32'h100, 32'h0, 1'b1);
    rq.push_back(32'h101);
    @(negedge clk);
    checks++;
    if (desync_err !== 1'b1) begin failures++; $display("FAIL desync_set: got %b expected 1", desync_err); end
    wait_pairs(1, 20);
    repeat (10) @(negedge clk);
    checks++;
    if (desync_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL desync_sticky: got err %b busy %b expected 1 0", desync_err, busy);
    end
    checks++;
    if (rd_res_cnt - r0 != 1 || got_q.size() != 1 || underflow != 0) begin
      failures++;
      $display("FAIL desync_reads: got pops %0d pairs %0d underflow %0d expected 1 1 0", rd_res_cnt - r0, got_q.size(), underflow);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL desync_pair: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_status_drop();
    logic [2*W-1:0] g, e;
    int n_exp;
    logic [CW-1:0] drops_exp;
    bit drop_on;
`ifdef PEA_RDR_STATUS_DROP_EN
    drop_on = 1'b1;
`else
    drop_on = 1'b0;
`endif
    apply_reset();
    @(negedge clk);
    push_pair(32'd10, 32'd0, 1'b1);
    push_pair(32'd20, 32'd1, !drop_on);
    push_pair(32'd30, 32'd0, 1'b1);
    n_exp = exp_q.size();
    drops_exp = drop_on ? CW'(1) : CW'(0);
    wait_pairs(n_exp, 60);
    repeat (8) @(negedge clk);
    checks++;
    if (got_q.size() != n_exp) begin failures++; $display("FAIL drop_delivered: got %0d expected %0d", got_q.size(), n_exp); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL drop_pair: got %h expected %h", g, e); end
    end
    checks++;
    if (drop_count !== drops_exp || pair_count !== CW'(n_exp)) begin
      failures++;
      $display("FAIL drop_counts: got drop %0d pairs %0d expected %0d %0d", drop_count, pair_count, drops_exp, n_exp);
    end
  endtask

  task automatic test_reset_in_capt();
    int r0;
    logic [2*W-1:0] g, e;
    apply_reset();
    @(negedge clk);
    push_pair(32'h77, 32'h0, 1'b0);
    push_pair(32'h88, 32'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, rd_en_result, pair_count, out_result} !== '0) begin
      failures++;
      $display("FAIL capt_reset_now: got valid %b busy %b rd %b cnt %0d res %h expected all zero", out_valid, busy, rd_en_result, pair_count, out_result);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL capt_reset_valid: got %b expected 0", out_valid); end
    end
    got_q.delete();
    r0 = rd_res_cnt;
    rst = 1'b1;
    wait_pairs(1, 30);
    repeat (6) @(negedge clk);
    checks++;
    if (got_q.size() != 1 || rd_res_cnt - r0 != 1 || pair_count !== 16'd1) begin
      failures++;
      $display("FAIL capt_recover: got pairs %0d pops %0d count %0d expected 1 1 1", got_q.size(), rd_res_cnt - r0, pair_count);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin failures++; $display("FAIL capt_pair: got %h expected %h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_desync();
    test_status_drop();
    test_reset_in_capt();
    checks++;
    if (rd_mis != 0) begin failures++; $display("FAIL rd_en_lockstep: got %0d split strobes expected 0", rd_mis); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pea_result_reader.md
Name: pea_result_reader

Overview:
Host-side consumer for the PEA output path. It drains the result and status output FIFOs, which are written in lockstep by the PEA wr_out strobe. Each popped pair is presented on a single valid/ready stream as {status, result}. It replaces bench-driven rd_en_result/rd_en_status pulsing and tracks pair count and FIFO desynchronisation.

Parameters:
buffer_size_out, 32, depth of each output FIFO
width, 32, word width of the result and status FIFOs
cnt_w, 16, width of the pair and drop counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
result_pop  input  log2(buffer_size_out)  population of the result FIFO
status_pop  input  log2(buffer_size_out)  population of the status FIFO
result_data  input  width  result FIFO read data
status_data  input  width  status FIFO read data
rd_en_result  output  1  result FIFO pop strobe
rd_en_status  output  1  status FIFO pop strobe
out_valid  output  1  pair available
out_ready  input  1  downstream accepts pair
out_result  output  width  held result word
out_status  output  width  held status word
pair_count  output  cnt_w  pairs delivered, wrapping
drop_count  output  cnt_w  pairs dropped (see Optional Feature)
desync_err  output  1  sticky: populations differed while idle
busy  output  1  high when state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0, including both rd_en strobes, out_* , counters and desync_err.
- FIFO read model: data is valid on the cycle after rd_en is high. rd_en_result and rd_en_status are always asserted together for exactly one cycle.
- IDLE:
  - If result_pop!=0 and status_pop!=0, go to POP.
  - If result_pop!=status_pop, set desync_err (sticky until reset). Reading still proceeds while both are non-zero.
- POP: assert both rd_en for 1 cycle, then go to CAPT.
- CAPT: register result_data into out_result and status_data into out_status, then go to HOLD.
- HOLD: out_valid=1; out_result/out_status are stable while out_valid && !out_ready.
  - On out_valid && out_ready: pair_count+1 (wraps at 2^cnt_w).
  - Then, if both pops are still non-zero, go directly to POP (no IDLE bubble); otherwise go to IDLE.
- Latency: pops non-zero at cycle 0 -> rd_en at cycle 1 -> out_valid at cycle 3. Sustained throughput is 1 pair per 3 cycles with out_ready tied high.
- out_valid drops in the cycle after acceptance.
- Populations are sampled only in IDLE and at HOLD exit, never during POP/CAPT.
- The block never pops an empty FIFO: if one population is 0, it waits in IDLE.
- out_ready is ignored outside HOLD.
- Reset mid-operation: the in-flight pair is lost, and the FIFOs keep any unread words.

Optional Feature:
- Macro PEA_RDR_STATUS_DROP_EN.
- Defined: in CAPT, a pair whose status_data[0]==1 (PEA error status) is not presented. It increments drop_count and returns to POP or IDLE using the HOLD-exit rule.
- Undefined: every pair is presented, and drop_count is constant 0.

Decomposition:
- Shared header pea_defs.vh holds:
  - log2 function
  - state encodings IDLE=2'd0, POP=2'd1, CAPT=2'd2, HOLD=2'd3
  - PEA status bit positions
- One natural sub-module, pea_pair_hold_reg: width-parameterised {status,result} holding register with load and valid/ready hold. The FSM and counters stay in the top module.

Test Plan:
- Reset: hold rst=0 with pops non-zero -> no rd_en, all outputs 0. Release -> rd_en at the first rising edge where IDLE sees both pops >0.
- Single pair: result FIFO=0x0000_002A, status FIFO=0x0000_0000, out_ready=1 -> out_valid 3 cycles after pops become 1; out_result=0x2A, out_status=0, pair_count=1, exactly one rd_en pulse each.
- Backpressure plus back-to-back: 3 pairs (results 1,2,3), out_ready low for 5 cycles on the 2nd pair -> outputs held stable, order 1,2,3, no extra pops, pair_count=3, final state IDLE.
- Desync: result_pop=2, status_pop=1 -> desync_err=1 stays set; exactly one pair read, then the reader waits in IDLE.
- Macro on: status sequence 0,1,0 with results 10,20,30 -> delivered 10,30; drop_count=1, pair_count=2. Macro off -> all three delivered, drop_count=0.
- Reset asserted during CAPT -> outputs 0 immediately, no out_valid; after release the next pair in the FIFO is read normally.
